btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Input-conditioning stage between the ULX3S board buttons and the FPGA top.
//  Synchronises raw btn pins, debounces them, produces clean levels,
//  press/release pulses and a stretched active-high system reset from the reset
//  button. Replaces the direct btn->gpio_in and !btn[0]->rst wiring.
// PARAMETERS
//  N_BTN       7        number of button inputs
//  IDLE_LEVEL  7'h01    released level per bit; btn[0] is active-low
//  DEB_CYCLES  250000   stable cycles before a level change is accepted (10 ms @ 25 MHz)
//  RST_BIT     0        button index that drives sys_rst
//  RST_HOLD    16       sys_rst stretch after reset button release, cycles
//  REP_DELAY   12500000 autorepeat first-repeat delay (BTN_AUTOREPEAT_EN only)
//  REP_PERIOD  2500000  autorepeat interval (BTN_AUTOREPEAT_EN only)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  btn_raw      in   N_BTN  asynchronous board button pins
//  btn_level    out  N_BTN  debounced level, same polarity as pins
//  btn_press    out  N_BTN  1-cycle pulse on debounced released->pressed
//  btn_release  out  N_BTN  1-cycle pulse on debounced pressed->released
//  sys_rst      out  1      active-high reset for fpga_top, stretched
// BEHAVIOUR
//  - One clock domain, clk. rst is synchronous, active-high; all state updates
//    on posedge clk.
//  - Reset values: sync flops = IDLE_LEVEL, btn_level = IDLE_LEVEL,
//    btn_press = btn_release = 0, per-bit counters = 0, sys_rst = 1,
//    stretch counter = RST_HOLD.
//  - Sync: 2-flop synchroniser per bit; only the 2nd flop (s) is used downstream.
//  - Debounce, per bit, counter width $clog2(DEB_CYCLES+1):
//    s == btn_level -> counter cleared to 0.
//    s != btn_level and counter < DEB_CYCLES-1 -> counter+1.
//    s != btn_level and counter == DEB_CYCLES-1 -> btn_level <= s, counter 0,
//    press or release pulse asserted for exactly that one cycle.
//  - Any bounce back to the old level before terminal count restarts the count.
//  - Latency from a clean pin edge to btn_level/pulse is 2+DEB_CYCLES cycles.
//  - pressed(i) = btn_level[i] != IDLE_LEVEL[i]. press/release follow pressed,
//    not raw polarity.
//  - Bits are independent; simultaneous transitions on several bits give pulses
//    in the same cycle.
//  - sys_rst: while pressed(RST_BIT), sys_rst = 1 and stretch = RST_HOLD.
//    After release, stretch decrements each cycle; sys_rst = 1 while
//    stretch != 0, then 0.
//  - A re-press during stretch reloads RST_HOLD.
//  - rst mid-debounce discards partial counts; no pulse is produced for the
//    aborted transition.
//  - No pulses in the cycle rst is high, or in the first cycle after it.
//  - DEB_CYCLES >= 2 required; RST_HOLD = 0 gives an unstretched reset.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//    - Each bit except RST_BIT gets a repeat counter.
//    - While pressed, an extra btn_press pulse fires REP_DELAY cycles after the
//      initial press pulse, then every REP_PERIOD cycles.
//    - Release or rst clears the repeat counter.
//  BTN_AUTOREPEAT_EN undefined:
//    - Repeat logic is absent; exactly one press pulse per debounced press.
// TESTING (bench: DEB_CYCLES=8, RST_HOLD=4, REP_DELAY=20, REP_PERIOD=5)
//  1. rst high 3 cycles, btn_raw=7'h01 -> btn_level=7'h01, no pulses,
//     sys_rst=1 for 4 cycles after rst drops.
//  2. btn_raw[3] 0->1 clean -> btn_level[3]=1 and btn_press=7'h08 for 1 cycle,
//     10 cycles after the edge.
//  3. btn_raw[3] toggles every 3 cycles for 30 cycles, then settles at 0 ->
//     btn_level never changes during toggling.
//  4. btn_raw[0] 1->0 held 20 cycles, then 1 -> sys_rst=1 from edge+10 until
//     release-debounce+4 cycles, then 0.
//  5. btn_raw[1] and btn_raw[2] rise in the same cycle -> btn_press=7'h06 in a
//     single cycle.
//  6. BTN_AUTOREPEAT_EN, btn_raw[4] held 40 cycles -> btn_press[4] pulses at
//     t0, t0+20, t0+25, t0+30, t0+35, where t0 = edge+10.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise and debounce buttons, emit press/release pulses and a stretched sys_rst.
// Optional autorepeat of press pulses on non-reset buttons is enabled with the macro BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int N_BTN = 7,
  parameter logic [N_BTN-1:0] IDLE_LEVEL = N_BTN'(7'h01),
  parameter int DEB_CYCLES = 250000,
  parameter int RST_BIT = 0,
  parameter int RST_HOLD = 16,
  parameter int REP_DELAY = 12500000,
  parameter int REP_PERIOD = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sys_rst
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int HW = RST_HOLD > 0 ? $clog2(RST_HOLD + 1) : 1;
  if (DEB_CYCLES < 2 || RST_HOLD < 0 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
    $error("btn_conditioner: invalid parameters");
  end
  logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d, release_q, release_d, chg;
  logic [CW-1:0] cnt_q [N_BTN];
  logic [CW-1:0] cnt_d [N_BTN];
  logic [HW-1:0] stretch_q, stretch_d;
  logic rst_pressed;
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2((REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD) + 1);
  logic [RW-1:0] rep_q [N_BTN];
  logic [RW-1:0] rep_d [N_BTN];
  logic [N_BTN-1:0] rep_done_q, rep_done_d, rep_fire;
`endif
  assign rst_pressed = level_q[RST_BIT] != IDLE_LEVEL[RST_BIT];
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    chg = '0;
    for (int i = 0; i < N_BTN; i++) begin
      chg[i] = sync2_q[i] != level_q[i] && cnt_q[i] == CW'(DEB_CYCLES - 1);
      cnt_d[i] = (sync2_q[i] == level_q[i] || chg[i]) ? '0 : cnt_q[i] + CW'(1);
    end
    level_d = level_q ^ chg;
    press_d = chg & (level_d ^ IDLE_LEVEL);
    release_d = chg & ~(level_d ^ IDLE_LEVEL);
`ifdef BTN_AUTOREPEAT_EN
    // First repeat after REP_DELAY, then every REP_PERIOD, while the level stays pressed
    rep_fire = '0;
    rep_done_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_d[i] = '0;
      if (i != RST_BIT && level_q[i] != IDLE_LEVEL[i] && !chg[i]) begin
        rep_fire[i] = rep_q[i] == (rep_done_q[i] ? RW'(REP_PERIOD - 1) : RW'(REP_DELAY - 1));
        rep_d[i] = rep_fire[i] ? '0 : rep_q[i] + RW'(1);
        rep_done_d[i] = rep_done_q[i] | rep_fire[i];
      end
    end
    press_d = press_d | rep_fire;
`endif
    stretch_d = rst_pressed ? HW'(RST_HOLD) : (stretch_q != '0 ? stretch_q - HW'(1) : stretch_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      level_q <= IDLE_LEVEL;
      press_q <= '0;
      release_q <= '0;
      cnt_q <= '{default: '0};
      stretch_q <= HW'(RST_HOLD);
`ifdef BTN_AUTOREPEAT_EN
      rep_q <= '{default: '0};
      rep_done_q <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
      cnt_q <= cnt_d;
      stretch_q <= stretch_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_q <= rep_d;
      rep_done_q <= rep_done_d;
`endif
    end
  end
  assign btn_level = level_q;
  assign btn_press = press_q;
  assign btn_release = release_q;
  assign sys_rst = rst_pressed || stretch_q != '0;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random stimulus against a window-based debounce reference model.
module tb_btn_conditioner;
  localparam int N = 7, DEB = 8, HOLD = 4, DELAY = 20, PERIOD = 5;
  localparam logic [6:0] IDLE = 7'h01;
  logic clk = 0, rst = 1;
  logic [6:0] btn_raw = IDLE;
  logic [6:0] btn_level, btn_press, btn_release;
  logic sys_rst;
  int vectors = 0, errors = 0;

  btn_conditioner #(.N_BTN(N), .IDLE_LEVEL(IDLE), .DEB_CYCLES(DEB), .RST_BIT(0), .RST_HOLD(HOLD),
    .REP_DELAY(DELAY), .REP_PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .sys_rst(sys_rst));

  always #5 clk = ~clk;

  // Reference: a level flips once the last DEB synchronised samples all disagree with it.
  int n = 0, last_p = -1000;
  int t0 [N];
  logic [6:0] sq [$];
  logic [6:0] prev_raw = IDLE, lvl = IDLE, ep = '0, er = '0;
  logic esys = 1'b1;
  always @(posedge clk) begin : model
    logic [6:0] newl, chg;
    n++;
    if (rst) begin
      sq.delete();
      sq.push_back(IDLE);
      prev_raw = IDLE;
      lvl = IDLE;
      ep = '0;
      er = '0;
      last_p = n - 1;
    end else begin
      chg = '0;
      if (sq.size() >= DEB)
        for (int i = 0; i < N; i++) begin
          chg[i] = 1'b1;
          foreach (sq[k]) if (sq[k][i] == lvl[i]) chg[i] = 1'b0;
        end
      newl = lvl ^ chg;
      ep = chg & (newl ^ IDLE);
      er = chg & ~(newl ^ IDLE);
      for (int i = 0; i < N; i++) if (ep[i]) t0[i] = n;
`ifdef BTN_AUTOREPEAT_EN
      for (int i = 1; i < N; i++)
        if (newl[i] != IDLE[i] && !chg[i] && n - t0[i] >= DELAY && (n - t0[i] - DELAY) % PERIOD == 0)
          ep[i] = 1'b1;
`endif
      lvl = newl;
      sq.push_back(prev_raw);
      if (sq.size() > DEB) void'(sq.pop_front());
      prev_raw = btn_raw;
    end
    if (lvl[0] != IDLE[0]) last_p = n;
    esys = (lvl[0] != IDLE[0]) || (n - last_p) <= HOLD;
  end

  task automatic test_reset();
    int hi;
    rst = 1;
    btn_raw = IDLE;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL reset n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (btn_level !== 7'h01 || btn_press !== 7'h00 || btn_release !== 7'h00 || sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got %h/%h/%h/%b exp 01/00/00/1", btn_level, btn_press, btn_release, sys_rst);
    end
    rst = 0;
    hi = int'(sys_rst);
    repeat (8) begin
      @(posedge clk); #1;
      hi += int'(sys_rst);
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL reset_stretch n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (hi !== 4) begin
      errors++;
      $display("FAIL reset_sys_rst_cycles got %0d exp 4", hi);
    end
  endtask

  task automatic test_clean_press();
    int e, po, ro, np;
    po = -1; ro = -1; np = 0;
    btn_raw[3] = 1'b1;
    e = n;
    repeat (14) begin
      @(posedge clk); #1;
      if (btn_press != 0) begin np++; if (btn_press === 7'h08) po = n - e; end
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL clean_press n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (po !== 10 || np !== 1) begin
      errors++;
      $display("FAIL clean_press_latency got offset %0d count %0d exp offset 10 count 1", po, np);
    end
    btn_raw[3] = 1'b0;
    e = n;
    repeat (14) begin
      @(posedge clk); #1;
      if (btn_release === 7'h08) ro = n - e;
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL clean_release n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (ro !== 10) begin
      errors++;
      $display("FAIL clean_release_latency got %0d exp 10", ro);
    end
  endtask

  task automatic test_bounce();
    int moved = 0;
    for (int t = 0; t < 45; t++) begin
      if (t < 30 && t % 3 == 0) btn_raw[3] = ~btn_raw[3];
      @(posedge clk); #1;
      if (btn_level[3] !== 1'b0 || btn_press[3] !== 1'b0) moved++;
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL bounce n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (moved !== 0) begin
      errors++;
      $display("FAIL bounce_level_stable got %0d changed cycles exp 0", moved);
    end
  endtask

  task automatic test_reset_button();
    int e, rise, fall;
    rise = -1; fall = -1;
    btn_raw[0] = 1'b0;
    e = n;
    for (int t = 0; t < 50; t++) begin
      if (t == 20) btn_raw[0] = 1'b1;
      @(posedge clk); #1;
      if (sys_rst === 1'b1 && rise < 0) rise = n - e;
      if (sys_rst === 1'b0 && rise >= 0 && fall < 0) fall = n - e;
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL reset_button n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (rise !== 10 || fall !== 34) begin
      errors++;
      $display("FAIL reset_button_window got rise %0d fall %0d exp rise 10 fall 34", rise, fall);
    end
  endtask

  task automatic test_simultaneous();
    int np = 0;
    logic [6:0] seen = '0;
    btn_raw[2:1] = 2'b11;
    repeat (14) begin
      @(posedge clk); #1;
      if (btn_press != 0) begin np++; seen = btn_press; end
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL simultaneous n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (np !== 1 || seen !== 7'h06) begin
      errors++;
      $display("FAIL simultaneous_pulse got %0d pulses last %h exp 1 pulse 06", np, seen);
    end
    btn_raw[2:1] = 2'b00;
    repeat (14) begin
      @(posedge clk); #1;
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL simultaneous_rel n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
  endtask

  task automatic test_rst_abort();
    int r, first, early;
    first = -1; early = 0;
    btn_raw[5] = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    r = n;
    rst = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (btn_press[5] === 1'b1 && first < 0) first = n - r;
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL rst_abort n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (first !== 10) begin
      errors++;
      $display("FAIL rst_abort_restart got first press offset %0d exp 10", first);
    end
    btn_raw[5] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic test_autorepeat();
    int e;
    int offs [$];
    int exp_offs [$];
`ifdef BTN_AUTOREPEAT_EN
    exp_offs = '{10, 30, 35, 40, 45};
`else
    exp_offs = '{10};
`endif
    btn_raw[4] = 1'b1;
    e = n;
    for (int t = 0; t < 56; t++) begin
      if (t == 40) btn_raw[4] = 1'b0;
      @(posedge clk); #1;
      if (btn_press[4] === 1'b1) offs.push_back(n - e);
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL autorepeat n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    vectors++;
    if (offs.size() !== exp_offs.size()) begin
      errors++;
      $display("FAIL autorepeat_count got %0d pulses exp %0d", offs.size(), exp_offs.size());
    end else
      foreach (exp_offs[k]) begin
        vectors++;
        if (offs[k] !== exp_offs[k]) begin
          errors++;
          $display("FAIL autorepeat_offset[%0d] got %0d exp %0d", k, offs[k], exp_offs[k]);
        end
      end
  endtask

  task automatic test_random();
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 9) == 0) btn_raw = btn_raw ^ 7'(1 << $urandom_range(0, 6));
      rst = ($urandom_range(0, 249) == 0);
      @(posedge clk); #1;
      vectors++;
      if ({btn_level, btn_press, btn_release, sys_rst} !== {lvl, ep, er, esys}) begin
        errors++;
        $display("FAIL random n=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, btn_level, btn_press, btn_release, sys_rst, lvl, ep, er, esys);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_reset_button();
    test_simultaneous();
    test_rst_abort();
    test_autorepeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
